// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
// Byte, halfword, word and doubleword stores into a word-organised memory.
// Partial-word stores are read-modify-write cycles. A store that crosses a
// word boundary becomes two read-modify-write passes, lower word first. The
// upper word address wraps modulo 2^ADDRESS_WIDTH.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready request handshake; ready only while idle
//   req_addr            byte address of the store
//   req_funct3          000 sb, 001 sh, 010 sw, 011 sd (sd only at 64 bits)
//   req_data            source value; the low N bytes are stored
//   mem_addr            word-aligned memory address (0 when no strobe)
//   mem_re              read strobe; mem_rdata is valid the following cycle
//   mem_rdata           memory read data
//   mem_we              write strobe, one cycle per word
//   mem_wdata           merged write word (0 when no write)
//   done                one-cycle pulse, store complete
//   err                 one-cycle pulse together with done, illegal funct3
// -----------------------------------------------------------------------------
module store_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 9,
    parameter int BYTE_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [2:0]               req_funct3,
    input  logic [DATA_WIDTH-1:0]    req_data,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_re,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     done,
    output logic                     err
);

    localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
    localparam int OFF_W = $clog2(LANES);

    typedef enum logic [2:0] {IDLE, RD0, WR0, RD1, WR1, ERR} state_t;

    state_t                     state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0]   addr_reg;
    logic [1:0]                 size_reg;
    logic [DATA_WIDTH-1:0]      data_reg;

    // Byte count for a size code. sd wraps to 0 at 32-bit width, but that
    // code is rejected as illegal before it is ever used.
    function automatic logic [OFF_W:0] size_bytes(input logic [1:0] code);
        return (OFF_W + 1)'(1) << code;
    endfunction

    function automatic logic is_legal(input logic [2:0] f3);
        return !f3[2] && ((f3[1:0] != 2'b11) || (DATA_WIDTH == 64));
    endfunction

    // ---- decode of the incoming request (used only while idle) ----
    logic             accept;
    logic [OFF_W-1:0] in_offset;
    logic             in_full;

    assign accept    = req_valid && (state_reg == IDLE);
    assign in_offset = req_addr[OFF_W-1:0];
    assign in_full   = (in_offset == '0) &&
                       (size_bytes(req_funct3[1:0]) == (OFF_W + 1)'(LANES));

    // ---- decode of the latched request ----
    logic [OFF_W-1:0]         offset;
    logic [OFF_W:0]           nbytes;
    logic                     split;
    logic                     full;
    logic [ADDRESS_WIDTH-1:0] word0;
    logic [ADDRESS_WIDTH-1:0] word1;

    assign offset = addr_reg[OFF_W-1:0];
    assign nbytes = size_bytes(size_reg);
    assign split  = ((OFF_W + 2)'(offset) + (OFF_W + 2)'(nbytes)) > (OFF_W + 2)'(LANES);
    assign full   = (offset == '0) && (nbytes == (OFF_W + 1)'(LANES));
    assign word0  = {addr_reg[ADDRESS_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign word1  = word0 + ADDRESS_WIDTH'(LANES);

    // ---- lane merge ----
    // For lane gi the source byte index is (gi - offset) mod LANES in both
    // words. It belongs to word0 when gi >= offset, otherwise to word1, and
    // only if the index is below the store size.
    logic [DATA_WIDTH-1:0] merged0;
    logic [DATA_WIDTH-1:0] merged1;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [OFF_W-1:0] LANE = OFF_W'(gi);
            logic [OFF_W-1:0] src;
            logic             hit;
            logic             in0;
            logic             in1;

            assign src = LANE - offset;
            assign hit = {1'b0, src} < nbytes;
            assign in0 = hit && (LANE >= offset);
            assign in1 = hit && (LANE <  offset);

            assign merged0[gi*BYTE_WIDTH +: BYTE_WIDTH] =
                in0 ? data_reg[src*BYTE_WIDTH +: BYTE_WIDTH]
                    : mem_rdata[gi*BYTE_WIDTH +: BYTE_WIDTH];
            assign merged1[gi*BYTE_WIDTH +: BYTE_WIDTH] =
                in1 ? data_reg[src*BYTE_WIDTH +: BYTE_WIDTH]
                    : mem_rdata[gi*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate

    // ---- state and request registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            size_reg  <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg <= req_addr;
                size_reg <= req_funct3[1:0];
                data_reg <= req_data;
            end
        end
    end

    // ---- next state and outputs ----
    // Outputs decode the state register only, so the asynchronous reset
    // clears every strobe at once.
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        mem_addr   = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        done       = 1'b0;
        err        = 1'b0;

        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!is_legal(req_funct3)) state_next = ERR;
                    else if (in_full)          state_next = WR0;
                    else                       state_next = RD0;
                end
            end
            RD0: begin
                mem_re     = 1'b1;
                mem_addr   = word0;
                state_next = WR0;
            end
            WR0: begin
                mem_we    = 1'b1;
                mem_addr  = word0;
                mem_wdata = full ? data_reg : merged0;
                if (split) begin
                    state_next = RD1;
                end else begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            RD1: begin
                mem_re     = 1'b1;
                mem_addr   = word1;
                state_next = WR1;
            end
            WR1: begin
                mem_we     = 1'b1;
                mem_addr   = word1;
                mem_wdata  = merged1;
                done       = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                done       = 1'b1;
                err        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
// Directed and random stores against a byte-addressed reference memory.
// The bench owns the word memory seen by the unit.
// -----------------------------------------------------------------------------
module tb_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [8:0]  req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_data = '0;
    logic [8:0]  mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    store_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(9), .BYTE_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_data(req_data),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Word memory with a bench-side preload port.
    logic [31:0] mem [128];
    logic        pre_we = 1'b0;
    logic [6:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    always @(posedge clk) begin
        if (pre_we)      mem[pre_idx] <= pre_val;
        else if (mem_we) mem[mem_addr[8:2]] <= mem_wdata;
        if (mem_re)      mem_rdata <= mem[mem_addr[8:2]];
    end

    // Reference: flat byte memory, stores applied byte by byte.
    logic [7:0] rmem [512];

    function automatic logic [31:0] ref_word(input int w);
        return {rmem[w+3], rmem[w+2], rmem[w+1], rmem[w]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int byte_addr, input logic [31:0] val);
        @(negedge clk);
        pre_we  = 1'b1;
        pre_idx = 7'(byte_addr >> 2);
        pre_val = val;
        @(negedge clk);
        pre_we  = 1'b0;
        for (int b = 0; b < 4; b++) rmem[(byte_addr & ~3) + b] = val[8*b +: 8];
    endtask

    // Observations of the last store.
    int          lat;
    logic        err_seen;
    int          re_cnt;
    int          we_cnt;
    int          proto_bad;
    logic [8:0]  waddr [2];

    task automatic sample_cycle();
        if (mem_re && mem_we) proto_bad++;
        if (!mem_re && !mem_we && (mem_addr != 0 || mem_wdata != 0)) proto_bad++;
        if (err && !done) proto_bad++;
        if (mem_re) re_cnt++;
        if (mem_we) begin
            if (we_cnt < 2) waddr[we_cnt] = mem_addr;
            we_cnt++;
        end
        if (err) err_seen = 1'b1;
    endtask

    task automatic run_store(input logic [8:0] a, input logic [2:0] f3, input logic [31:0] d);
        int cyc;
        @(negedge clk);
        chk("ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_addr = a; req_funct3 = f3; req_data = d;
        lat = -1; err_seen = 1'b0; re_cnt = 0; we_cnt = 0; proto_bad = 0;
        waddr[0] = '0; waddr[1] = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        forever begin
            sample_cycle();
            if (done) begin lat = cyc; break; end
            if (cyc >= 10) break;
            @(negedge clk);
            cyc++;
        end
    endtask

    // Issues a store, applies it to the reference and checks everything.
    task automatic do_store(input string nm, input logic [8:0] a, input logic [2:0] f3,
                            input logic [31:0] d);
        int  n, off, w0, w1, exp_lat, exp_re, exp_we;
        bit  legal, split, full;
        n     = 1 << f3[1:0];
        legal = (f3[2] == 1'b0) && (n <= 4);
        off   = int'(a) % 4;
        w0    = int'(a) - off;
        w1    = (w0 + 4) % 512;
        split = legal && (off + n > 4);
        full  = legal && (off == 0) && (n == 4);
        exp_lat = !legal ? 1 : full ? 1 : split ? 4 : 2;
        exp_re  = !legal ? 0 : full ? 0 : split ? 2 : 1;
        exp_we  = !legal ? 0 : split ? 2 : 1;
        if (legal)
            for (int k = 0; k < n; k++) rmem[(int'(a) + k) % 512] = d[8*k +: 8];

        run_store(a, f3, d);
        @(posedge clk); #1;
        $display("store %s addr=%03h f3=%0d data=%08h lat=%0d err=%0b re=%0d we=%0d",
                 nm, a, f3, d, lat, err_seen, re_cnt, we_cnt);
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_err"}, 64'(err_seen), 64'(!legal));
        chk({nm, "_re_count"}, 64'(re_cnt), 64'(exp_re));
        chk({nm, "_we_count"}, 64'(we_cnt), 64'(exp_we));
        chk({nm, "_protocol"}, 64'(proto_bad), 64'd0);
        if (legal) begin
            chk({nm, "_waddr0"}, 64'(waddr[0]), 64'(w0));
            chk({nm, "_word0"}, 64'(mem[w0 >> 2]), 64'(ref_word(w0)));
        end
        if (split) begin
            chk({nm, "_waddr1"}, 64'(waddr[1]), 64'(w1));
            chk({nm, "_word1"}, 64'(mem[w1 >> 2]), 64'(ref_word(w1)));
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rmem[i] = 8'h00;

        // Reset state, sampled while reset is held.
        #2;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_re",    64'(mem_re),    64'd0);
        chk("rst_we",    64'(mem_we),    64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_err",   64'(err),       64'd0);
        chk("rst_addr",  64'(mem_addr),  64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        for (int i = 0; i < 128; i++) preload(i * 4, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Byte store inside a word.
        preload(9'h004, 32'h11223344);
        do_store("sb", 9'h005, 3'b000, 32'h000000AB);
        chk("sb_value", 64'(mem[1]), 64'h1122AB44);

        // Full word, no read.
        do_store("sw", 9'h008, 3'b010, 32'hDEADBEEF);
        chk("sw_value", 64'(mem[2]), 64'hDEADBEEF);

        // Halfword split across words.
        preload(9'h004, 32'h11223344);
        preload(9'h008, 32'h55667788);
        do_store("sh_split", 9'h007, 3'b001, 32'h0000CAFE);
        chk("sh_split_w0", 64'(mem[1]), 64'hFE223344);
        chk("sh_split_w1", 64'(mem[2]), 64'h556677CA);

        // Word split with address wrap.
        preload(9'h1FC, 32'h0);
        preload(9'h000, 32'h0);
        do_store("sw_wrap", 9'h1FE, 3'b010, 32'hA1B2C3D4);
        chk("sw_wrap_hi", 64'(mem[127]), 64'hC3D40000);
        chk("sw_wrap_lo", 64'(mem[0]),   64'h0000A1B2);

        // Illegal sizes.
        do_store("sd_illegal", 9'h010, 3'b011, 32'h12345678);
        do_store("f100_illegal", 9'h014, 3'b100, 32'h87654321);

        // Reset during the second read of a split store.
        preload(9'h004, 32'h11223344);
        preload(9'h008, 32'h55667788);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 9'h007; req_funct3 = 3'b001; req_data = 32'h0000CAFE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rd1_re",   64'(mem_re),   64'd1);
        chk("rd1_addr", 64'(mem_addr), 64'h008);
        rst_n = 1'b0;
        #1;
        chk("midrst_re",    64'(mem_re),    64'd0);
        chk("midrst_we",    64'(mem_we),    64'd0);
        chk("midrst_done",  64'(done),      64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_w1_kept", 64'(mem[2]), 64'h55667788);
        chk("midrst_w0_done", 64'(mem[1]), 64'hFE223344);
        rmem[7] = 8'hFE;
        $display("store midrst addr=007 f3=1 data=0000cafe word0=%08h word1=%08h", mem[1], mem[2]);

        // Random stores, including illegal codes and boundary addresses.
        for (int t = 0; t < 60; t++) begin
            logic [8:0]  a;
            logic [2:0]  f3;
            logic [31:0] d;
            a  = 9'($urandom_range(0, 511));
            if (t % 8 == 0) a = 9'h1FF - 9'($urandom_range(0, 2));
            f3 = 3'($urandom_range(0, 5));
            d  = $urandom;
            do_store("rand", a, f3, d);
        end

        // Whole-memory sweep against the reference.
        begin
            int bad;
            bad = 0;
            for (int w = 0; w < 128; w++) if (mem[w] !== ref_word(w * 4)) bad++;
            chk("final_memory_words_bad", 64'(bad), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 9, byte-address width.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8, lane width in bits.
REQ-004 clk  input  1  sole clock, rising edge; one clock, all state on clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  store request present.
REQ-007 req_ready  output  1  unit can accept a request.
REQ-008 req_addr  input  ADDRESS_WIDTH  byte address of store.
REQ-009 req_funct3  input  3  000 sb, 001 sh, 010 sw, 011 sd.
REQ-010 req_data  input  DATA_WIDTH  rs2 value; low bytes stored.
REQ-011 mem_addr  output  ADDRESS_WIDTH  word-aligned memory address.
REQ-012 mem_re  output  1  memory read strobe; mem_rdata valid the following cycle.
REQ-013 mem_rdata  input  DATA_WIDTH  memory read data.
REQ-014 mem_we  output  1  memory write strobe, one cycle per word.
REQ-015 mem_wdata  output  DATA_WIDTH  merged write word.
REQ-016 done  output  1  one-cycle pulse: store complete.
REQ-017 err  output  1  one-cycle pulse with done: illegal funct3.

Function
REQ-018 Handshake: request accepted on rising edge with req_valid=1 and req_ready=1; req_ready=1 only in IDLE; request fields latched at acceptance.
REQ-019 Size N bytes = 1, 2, 4, 8 for funct3 000/001/010/011; funct3 011 legal only when DATA_WIDTH=64; funct3[2]=1 or funct3=011 at DATA_WIDTH=32 is illegal.
REQ-020 L = DATA_WIDTH/BYTE_WIDTH lanes; offset = req_addr mod L; word0 = req_addr with low log2(L) bits cleared; word1 = word0 + L, modulo 2^ADDRESS_WIDTH.
REQ-021 Little-endian: byte k (k=0..N-1) of req_data goes to lane offset+k of word0 if offset+k < L, else lane offset+k-L of word1; all other lanes keep mem_rdata bytes.
REQ-022 Split store: offset+N > L; requires two read-modify-write passes, word0 first.
REQ-023 FSM states: IDLE, RD0, WR0, RD1, WR1, ERR.
REQ-024 IDLE -> ERR if illegal; -> WR0 if offset=0 and N=L (full-word store, no read); else -> RD0.
REQ-025 RD0: mem_re=1, mem_addr=word0; -> WR0.
REQ-026 WR0: mem_we=1, mem_addr=word0, mem_wdata=merge(mem_rdata) or req_data for full-word; -> RD1 if split, else IDLE with done=1 this cycle.
REQ-027 RD1: mem_re=1, mem_addr=word1; -> WR1.
REQ-028 WR1: mem_we=1, mem_addr=word1, mem_wdata=merged word1; done=1; -> IDLE.
REQ-029 ERR: done=1, err=1, no mem_re/mem_we; -> IDLE.
REQ-030 Latency acceptance-to-done: full-word 1 cycle, in-word 2 cycles, split 4 cycles, illegal 1 cycle; back-to-back acceptance allowed the cycle after done.
REQ-031 mem_re and mem_we SHALL never be asserted together; outside RD/WR states mem_addr=0 and mem_wdata=0.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, mem_re=0, mem_we=0, done=0, err=0, mem_addr=0, mem_wdata=0, req_ready=1 and clear latched request.
REQ-033 Reset mid-operation SHALL drop the pending store; any unwritten word of a split store stays unwritten.

Verification (DATA_WIDTH=32, ADDRESS_WIDTH=9)
REQ-034 sb addr 0x005 data 0x000000AB, mem[0x004]=0x11223344 -> RD0 addr 0x004, then WR0 addr 0x004 wdata 0x1122AB44, done.
REQ-035 sw addr 0x008 data 0xDEADBEEF -> no mem_re; next cycle mem_we addr 0x008 wdata 0xDEADBEEF, done.
REQ-036 sh addr 0x007 data 0x0000CAFE, mem[0x004]=0x11223344, mem[0x008]=0x55667788 -> write 0x004=0xFE223344, write 0x008=0x556677CA, done in 4th cycle.
REQ-037 sw addr 0x1FE data 0xA1B2C3D4, mem[0x1FC]=0, mem[0x000]=0 -> write 0x1FC=0xC3D40000, write 0x000=0x0000A1B2 (wrap).
REQ-038 funct3=011 -> next cycle done=1, err=1, no mem strobes; funct3=100 same.
REQ-039 rst_n=0 during RD1 of REQ-036 case -> mem_re=0 immediately, req_ready=1 after release, mem[0x008] unchanged.
